mult_accumulator: RTL

- Downstream consumer of the 4x4 array multiplier's 8-bit product.
- Sums a programmable run of 1..16 products into a saturating accumulator.
- Presents the result on a valid/ready output port.
- Provides a registered, handshaked multiply-accumulate back end for the TinyTapeout tile.

---
 rtl/mult_accumulator.sv | 118 +++++++++++
 1 files changed

// File: rtl/mult_accumulator.sv
// Saturating multiply-accumulate back end: sums a run of 1..2^LEN_W 8-bit products
// and presents the total on a valid/ready port. Define MACC_CLEAR_EN to add a synchronous clear input.
module mult_accumulator #(
    parameter int ACC_W = 12,
    parameter int LEN_W = 4
) (
`ifdef MACC_CLEAR_EN
    input  logic             clear,
`endif
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       product,
    input  logic [LEN_W-1:0] len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [LEN_W:0]   count_q;
    logic [LEN_W:0]   target_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [ACC_W:0]   sum_d;
    logic [LEN_W:0]   tgt_d;
    logic [LEN_W:0]   cnt_inc_d;
    logic             beat_d;

    // One spare sum bit catches the carry out that triggers saturation.
    assign sum_d     = {1'b0, acc_q} + (ACC_W+1)'(product);
    assign tgt_d     = (len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len};
    assign cnt_inc_d = count_q + (LEN_W+1)'(1);
    assign beat_d    = in_valid & in_ready_q;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign acc_out   = acc_q;
    assign overflow  = ovf_q;
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            target_q    <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
`ifdef MACC_CLEAR_EN
            if (clear) begin
                state_q     <= IDLE;
                acc_q       <= '0;
                count_q     <= '0;
                ovf_q       <= 1'b0;
                in_ready_q  <= 1'b1;
                out_valid_q <= 1'b0;
            end else
`endif
            begin
                case (state_q)
                    IDLE: begin
                        in_ready_q <= 1'b1;
                        if (beat_d) begin
                            target_q <= tgt_d;
                            acc_q    <= ACC_W'(product);
                            count_q  <= (LEN_W+1)'(1);
                            ovf_q    <= 1'b0;
                            if (tgt_d == (LEN_W+1)'(1)) begin
                                state_q     <= HOLD;
                                in_ready_q  <= 1'b0;
                                out_valid_q <= 1'b1;
                            end else begin
                                state_q <= ACCUM;
                            end
                        end
                    end
                    ACCUM: begin
                        if (beat_d) begin
                            acc_q   <= sum_d[ACC_W] ? {ACC_W{1'b1}} : sum_d[ACC_W-1:0];
                            ovf_q   <= ovf_q | sum_d[ACC_W];
                            count_q <= cnt_inc_d;
                            if (cnt_inc_d == target_q) begin
                                state_q     <= HOLD;
                                in_ready_q  <= 1'b0;
                                out_valid_q <= 1'b1;
                            end
                        end
                    end
                    HOLD: begin
                        // No turnaround: in_ready only returns once the result is gone.
                        if (out_ready) begin
                            state_q     <= IDLE;
                            out_valid_q <= 1'b0;
                            in_ready_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q     <= IDLE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
